// File: rtl/idu_pipe_pkg.sv
// Shared decode definitions for the NPC instruction-decode stage: ALU op codes,
// control-word bit positions, opcodes, immediate forms and the registered bundle layout.
package idu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;
    localparam logic [3:0] ALU_BEQ  = 4'hA;
    localparam logic [3:0] ALU_BNE  = 4'hB;
    localparam logic [3:0] ALU_BLT  = 4'hC;
    localparam logic [3:0] ALU_BGE  = 4'hD;
    localparam logic [3:0] ALU_BLTU = 4'hE;
    localparam logic [3:0] ALU_BGEU = 4'hF;
    localparam logic [3:0] ALU_PASS_IMM = 4'hA;
    localparam logic [3:0] ALU_CSR      = 4'hC;

    localparam int CTRL_MEM_READ  = 0;
    localparam int CTRL_MEM_WRITE = 1;
    localparam int CTRL_REG_WRITE = 2;
    localparam int CTRL_ALU_SRC   = 3;
    localparam int CTRL_MEM2REG   = 4;
    localparam int CTRL_BRANCH    = 5;
    localparam int CTRL_JAL       = 6;
    localparam int CTRL_JALR      = 7;
    localparam int CTRL_AUIPC     = 8;
    localparam int CTRL_ECALL     = 9;
    localparam int CTRL_EBREAK    = 10;
    localparam int CTRL_MRET      = 11;
    localparam int CTRL_CSR_OP    = 12;
    localparam int CTRL_CSR_WR    = 13;
    localparam int CTRL_CSR_IMM   = 14;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_ALT = 7'b0100000;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z} imm_type_e;

    // Width-independent part of the decoded bundle; register indices travel alongside.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [2:0]  funct3;
        logic [15:0] ctrl;
        logic        illegal;
    } idu_fix_t;

    function automatic logic [31:0] imm_gen(input logic [31:0] i, input imm_type_e t);
        case (t)
            IMM_I:   imm_gen = {{20{i[31]}}, i[31:20]};
            IMM_S:   imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   imm_gen = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   imm_gen = {i[31:12], 12'b0};
            IMM_J:   imm_gen = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            IMM_Z:   imm_gen = {20'b0, i[31:20]};
            default: imm_gen = 32'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of_funct3(input logic [2:0] f3);
        case (f3)
            3'd0:    alu_of_funct3 = ALU_ADD;
            3'd1:    alu_of_funct3 = ALU_SLL;
            3'd2:    alu_of_funct3 = ALU_SLT;
            3'd3:    alu_of_funct3 = ALU_SLTU;
            3'd4:    alu_of_funct3 = ALU_XOR;
            3'd5:    alu_of_funct3 = ALU_SRL;
            3'd6:    alu_of_funct3 = ALU_OR;
            default: alu_of_funct3 = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/idu_pipe_if.sv
// Fetch-side and execute-side handshake bundles of the decode stage.
// The producer of each bundle uses the master modport.
interface idu_fetch_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    modport master (output in_valid, in_inst, in_pc, input in_ready);
    modport slave  (input in_valid, in_inst, in_pc, output in_ready);
endinterface

interface idu_exu_if #(parameter int REG_AW = 4);
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [REG_AW-1:0] out_rs1;
    logic [REG_AW-1:0] out_rs2;
    logic [REG_AW-1:0] out_rd;
    logic [31:0]       out_imm;
    logic [3:0]        out_alu_op;
    logic [2:0]        out_funct3;
    logic [15:0]       out_ctrl;
    logic              out_illegal;
    modport master (output out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
                    out_alu_op, out_funct3, out_ctrl, out_illegal, input out_ready);
    modport slave  (input out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
                    out_alu_op, out_funct3, out_ctrl, out_illegal, output out_ready);
endinterface

// File: rtl/idu_pipe_dec.sv
// Combinational RV32I/E + Zicsr decoder: instruction word to register indices,
// immediate, ALU op, control word and an illegal-encoding flag.
module idu_dec
    import idu_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int EN_CSR = 1
) (
    input  logic [31:0]       inst_i,
    output logic [REG_AW-1:0] rs1_o,
    output logic [REG_AW-1:0] rs2_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [31:0]       imm_o,
    output logic [3:0]        alu_op_o,
    output logic [15:0]       ctrl_o,
    output logic              illegal_o
);
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [11:0] sys_imm;
    logic [15:0] ctrl;
    logic        ill, use_rs1, use_rs2, use_rd;
    imm_type_e   imm_t;

    assign f3      = inst_i[14:12];
    assign f7      = inst_i[31:25];
    assign sys_imm = inst_i[31:20];
    assign rs1_o   = inst_i[15 +: REG_AW];
    assign rs2_o   = inst_i[20 +: REG_AW];
    assign rd_o    = inst_i[7 +: REG_AW];

    always_comb begin
        ctrl     = '0;
        alu_op_o = ALU_ADD;
        imm_t    = IMM_NONE;
        ill      = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        use_rd   = 1'b0;
        case (inst_i[6:0])
            OPC_LUI: begin
                ctrl[CTRL_REG_WRITE] = 1'b1; ctrl[CTRL_ALU_SRC] = 1'b1;
                alu_op_o = ALU_PASS_IMM; imm_t = IMM_U; use_rd = 1'b1;
            end
            OPC_AUIPC: begin
                ctrl[CTRL_REG_WRITE] = 1'b1; ctrl[CTRL_ALU_SRC] = 1'b1; ctrl[CTRL_AUIPC] = 1'b1;
                imm_t = IMM_U; use_rd = 1'b1;
            end
            OPC_JAL: begin
                ctrl[CTRL_REG_WRITE] = 1'b1; ctrl[CTRL_JAL] = 1'b1;
                imm_t = IMM_J; use_rd = 1'b1;
            end
            OPC_JALR: begin
                ctrl[CTRL_REG_WRITE] = 1'b1; ctrl[CTRL_JALR] = 1'b1; ctrl[CTRL_ALU_SRC] = 1'b1;
                imm_t = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1;
                ill = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                ctrl[CTRL_BRANCH] = 1'b1;
                imm_t = IMM_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
                case (f3)
                    3'd0:    alu_op_o = ALU_BEQ;
                    3'd1:    alu_op_o = ALU_BNE;
                    3'd4:    alu_op_o = ALU_BLT;
                    3'd5:    alu_op_o = ALU_BGE;
                    3'd6:    alu_op_o = ALU_BLTU;
                    3'd7:    alu_op_o = ALU_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                ctrl[CTRL_MEM_READ] = 1'b1; ctrl[CTRL_REG_WRITE] = 1'b1;
                ctrl[CTRL_ALU_SRC] = 1'b1; ctrl[CTRL_MEM2REG] = 1'b1;
                imm_t = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1;
                ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
            end
            OPC_STORE: begin
                ctrl[CTRL_MEM_WRITE] = 1'b1; ctrl[CTRL_ALU_SRC] = 1'b1;
                imm_t = IMM_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
                ill = (f3 >= 3'd3);
            end
            OPC_OPIMM: begin
                ctrl[CTRL_REG_WRITE] = 1'b1; ctrl[CTRL_ALU_SRC] = 1'b1;
                imm_t = IMM_I; use_rs1 = 1'b1; use_rd = 1'b1;
                alu_op_o = alu_of_funct3(f3);
                // Shift-immediates reuse funct7; only SRAI may carry the alternate pattern.
                if (f3 == 3'd1 && f7 != 7'd0) ill = 1'b1;
                if (f3 == 3'd5) begin
                    if (f7 == F7_ALT)     alu_op_o = ALU_SRA;
                    else if (f7 != 7'd0)  ill = 1'b1;
                end
            end
            OPC_OP: begin
                ctrl[CTRL_REG_WRITE] = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1; use_rd = 1'b1;
                alu_op_o = alu_of_funct3(f3);
                if (f7 == F7_ALT) begin
                    if (f3 == 3'd0)      alu_op_o = ALU_SUB;
                    else if (f3 == 3'd5) alu_op_o = ALU_SRA;
                    else                 ill = 1'b1;
                end else if (f7 != 7'd0) begin
                    ill = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                imm_t = IMM_Z;
                if (f3 == 3'd0) begin
                    if (inst_i[19:15] != 5'd0 || inst_i[11:7] != 5'd0) ill = 1'b1;
                    case (sys_imm)
                        12'h000: ctrl[CTRL_ECALL]  = 1'b1;
                        12'h001: ctrl[CTRL_EBREAK] = 1'b1;
                        12'h302: ctrl[CTRL_MRET]   = 1'b1;
                        default: ill = 1'b1;
                    endcase
                end else if (f3 == 3'd4) begin
                    ill = 1'b1;
                end else begin
                    ctrl[CTRL_CSR_OP] = 1'b1; ctrl[CTRL_REG_WRITE] = 1'b1;
                    ctrl[CTRL_CSR_IMM] = f3[2];
                    // Set/clear with a zero source leaves the CSR untouched.
                    ctrl[CTRL_CSR_WR] = (f3[1:0] == 2'b01) || (inst_i[19:15] != 5'd0);
                    alu_op_o = ALU_CSR; use_rd = 1'b1; use_rs1 = !f3[2];
                    if (EN_CSR == 0) ill = 1'b1;
                end
            end
            default: ill = 1'b1;
        endcase
        if (inst_i[1:0] != 2'b11) ill = 1'b1;
        if (REG_AW < 5 && ((use_rs1 && inst_i[19]) || (use_rs2 && inst_i[24]) || (use_rd && inst_i[11])))
            ill = 1'b1;
    end

    assign imm_o     = imm_gen(inst_i, imm_t);
    assign ctrl_o    = ill ? 16'h0000 : ctrl;
    assign illegal_o = ill;

endmodule

// File: rtl/idu_pipe.sv
// Registered decode stage between IFU and EXU: decoder, output register,
// optional skid entry for full throughput under backpressure, flush and bundle counter.
module idu_pipe
    import idu_pkg::*;
#(
    parameter int REG_AW = 4,
    parameter int SKID   = 1,
    parameter int EN_CSR = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    idu_fetch_if.slave  fetch_i,
    idu_exu_if.master   exu_o,
    output logic [31:0] dec_cnt
);
    localparam int FIXW = $bits(idu_fix_t);
    localparam int BW   = FIXW + 3 * REG_AW;

    logic [REG_AW-1:0] dec_rs1, dec_rs2, dec_rd;
    logic [31:0]       dec_imm;
    logic [3:0]        dec_alu;
    logic [15:0]       dec_ctrl;
    logic              dec_ill;
    idu_fix_t          new_fix, out_fix;
    logic [BW-1:0]     new_b;
    logic [BW-1:0]     out_q, out_d, skid_q, skid_d;
    logic              out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              in_ready, accept, out_fire;

    idu_dec #(.REG_AW(REG_AW), .EN_CSR(EN_CSR)) u_dec (
        .inst_i    (fetch_i.in_inst),
        .rs1_o     (dec_rs1),
        .rs2_o     (dec_rs2),
        .rd_o      (dec_rd),
        .imm_o     (dec_imm),
        .alu_op_o  (dec_alu),
        .ctrl_o    (dec_ctrl),
        .illegal_o (dec_ill)
    );

    always_comb begin
        new_fix.pc      = fetch_i.in_pc;
        new_fix.imm     = dec_imm;
        new_fix.alu_op  = dec_alu;
        new_fix.funct3  = fetch_i.in_inst[14:12];
        new_fix.ctrl    = dec_ctrl;
        new_fix.illegal = dec_ill;
    end
    assign new_b = {new_fix, dec_rs1, dec_rs2, dec_rd};

    // With the skid entry, in_ready comes straight from a flop; without it the
    // stage can only refill its single register when EXU takes the current bundle.
    assign in_ready = (SKID != 0) ? !skid_valid_q : (!out_valid_q || exu_o.out_ready);
    assign accept   = fetch_i.in_valid && in_ready;
    assign out_fire = out_valid_q && exu_o.out_ready;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q + {31'b0, out_fire};
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (SKID != 0) begin
            if (!out_valid_q || out_fire) begin
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    out_d       = new_b;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_d       = new_b;
                skid_valid_d = 1'b1;
            end
        end else begin
            if (accept) begin
                out_d       = new_b;
                out_valid_d = 1'b1;
            end else if (out_fire) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            cnt_q        <= 32'd0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_fix             = out_q[BW-1:3*REG_AW];
    assign exu_o.out_rs1       = out_q[3*REG_AW-1:2*REG_AW];
    assign exu_o.out_rs2       = out_q[2*REG_AW-1:REG_AW];
    assign exu_o.out_rd        = out_q[REG_AW-1:0];
    assign exu_o.out_pc        = out_fix.pc;
    assign exu_o.out_imm       = out_fix.imm;
    assign exu_o.out_alu_op    = out_fix.alu_op;
    assign exu_o.out_funct3    = out_fix.funct3;
    assign exu_o.out_ctrl      = out_fix.ctrl;
    assign exu_o.out_illegal   = out_fix.illegal;
    assign exu_o.out_valid     = out_valid_q;
    assign fetch_i.in_ready    = in_ready;
    assign dec_cnt             = cnt_q;

endmodule

// File: doc/idu_pipe.md
Name: idu_pipe

Overview:
Registered, parametrised instruction-decode stage for the NPC core. It sits between the IFU fetch output and the EXU input, and carries valid/ready handshakes on both sides.
- Optional 2-entry skid buffer gives full throughput under backpressure.
- Register-file size is configurable (RV32E/RV32I).
- Flags illegal encodings instead of silently defaulting them.
- Decodes the full Zicsr set (CSRRW/S/C and the immediate forms).

Parameters:
REG_AW, 4, register index width; 4 = RV32E (16 regs), 5 = RV32I.
SKID, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single output register (in_ready = !out_valid || out_ready).
EN_CSR, 1, 1 = decode Zicsr; 0 = SYSTEM funct3 != 0 is illegal.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  drop all held and incoming instructions (branch/trap redirect).
in_valid  in  1  IFU offers instruction.
in_ready  out  1  stage accepts this cycle.
in_inst  in  32  instruction word.
in_pc  in  32  instruction PC.
out_valid  out  1  decoded bundle valid.
out_ready  in  1  EXU accepts bundle.
out_pc  out  32  PC of bundle.
out_rs1/out_rs2/out_rd  out  REG_AW each  register indices (low REG_AW bits of the fields).
out_imm  out  32  immediate.
out_alu_op  out  4  ALU opcode (idu_pkg).
out_funct3  out  3  inst[14:12].
out_ctrl  out  16  packed control word (idu_pkg).
out_illegal  out  1  illegal encoding.
dec_cnt  out  32  count of bundles handed to EXU.

Behaviour:
- Reset (rst_n low, async): out_valid=0, in_ready=1, skid entry empty, dec_cnt=0. All data outputs =0; no data update while out_valid=0.
- Latency: inst accepted at edge N (in_valid && in_ready) appears with out_valid=1 after edge N. Decode is combinational on in_inst and registered once.
- Handshake:
  - Transfer on valid && ready.
  - out_valid and all out_* stay stable while out_valid && !out_ready.
  - in_valid never gates in_ready.
- SKID=1:
  - If the output is stalled, an accepted bundle goes to the skid entry.
  - in_ready = !skid_full.
  - On drain, the skid entry moves to the output.
  - Strict program order.
  - Sustained 1/cycle with out_ready=1.
- SKID=0: in_ready = !out_valid || out_ready, combinational path.
- flush (sync, highest priority):
  - Next edge: out_valid=0, skid empty.
  - Any in transfer in the same cycle is discarded.
  - The out transfer in the same cycle still counts if out_ready=1.
- dec_cnt: +1 per out transfer, wraps at 2^32.
- ALU op codes: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9. Branches BEQ..BGEU A,B,C,D,E,F. LUI pass-imm A. CSR pass C.
- SLTIU is always 4, with no SEQZ special case.
- SUB/SRA are selected only when funct7=0100000. Any other nonzero funct7 on R-type, or on SLLI/SRLI/SRAI, is illegal.
- Immediates: I/S/B/U/J forms are sign-extended. CSR ops: imm = zero-extended csr addr {20'b0,inst[31:20]}; the uimm form places zimm=inst[19:15] in bits of out_rs1.
- out_ctrl bits (LSB first): mem_read, mem_write, reg_write, alu_src, mem_to_reg, branch, jal, jalr, auipc, ecall, ebreak, mret, csr_op, csr_wr, csr_imm, rsvd.
- csr_wr = 0 for CSRRS/CSRRC when rs1=0, and for CSRRSI/CSRRCI when zimm=0. It is always 1 for CSRRW/CSRRWI.
- illegal =1 for any of:
  - unknown opcode, or inst[1:0]!=11;
  - branch funct3 2/3;
  - load funct3 3/6/7;
  - store funct3 >=3;
  - JALR funct3!=0;
  - SYSTEM funct3=0 with imm not in {0,1,0x302} or rs1/rd!=0;
  - SYSTEM funct3=4;
  - CSR ops when EN_CSR=0;
  - REG_AW=4 and any *used* rs1/rs2/rd field has bit4=1.
- When illegal: out_ctrl forced to 0 (no writes, no mem), out_pc/out_inst fields are still valid, and the bundle still handshakes normally.

Decomposition:
- idu_pkg: ALU op localparams, out_ctrl bit indices, opcode localparams, imm-type enum.
- One combinational sub-module idu_dec (inst -> rs/rd/imm/alu_op/ctrl/illegal, parametrised REG_AW, EN_CSR).
- idu_pipe holds the handshake registers, skid entry, flush and counter.

Test Plan:
1. Reset, then 0x00500093 (addi x1,x0,5) with out_ready=1 -> one cycle later out_valid=1, imm=5, rd=1, alu_op=0, reg_write=1, alu_src=1, illegal=0, dec_cnt=1.
2. REG_AW=4: 0x00500813 (rd=x16) -> illegal=1, out_ctrl=0. REG_AW=5: same inst is legal with rd=16.
3. SKID=1, stream 4 insts, out_ready low for 3 cycles -> in_ready falls after 2 accepted. No loss or duplication; out_pc order A,B,C,D; 1/cycle once ready.
4. 0x300022F3 (csrrs x5,mstatus,x0) -> csr_op=1, csr_wr=0, imm=0x300, alu_op=C. 0x30029073 (csrrw) -> csr_wr=1.
5. 0xFE000EE3 (beq x0,x0,-4) -> branch=1, alu_op=A, imm=0xFFFFFFFC. Assert flush with skid full -> next cycle out_valid=0, and the concurrent input is dropped.
6. rst_n low mid-stall with out_valid=1 -> out_valid=0 immediately (async), dec_cnt=0; first post-reset accept behaves as in scenario 1.
